moving_avg_stage: RTL and testbench
===================================

Name: moving_avg_stage

Overview:
Sample-rate moving-average stage between the noise-injection adder and the audio codec write port; one instance per channel. Accepts one signed 24-bit sample per input handshake (driven by read_ready) and emits the mean of the last 2^LOG_N accepted samples through a valid/ready output register (consumed by write_ready/write). A circular sample buffer plus a running sum give one-sample latency independent of tap count. A bypass input passes the raw sample through without disturbing the filter history.

Parameters:
W, 24, sample width in bits; two's-complement signed.
LOG_N, 3, log2 of tap count; N = 2^LOG_N taps; legal range 1..6.

Ports:
CLOCK_50  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  input sample present (tied to codec read_ready).
in_ready  output  1  stage can accept a sample this cycle (drives codec read).
in_data  input  W  signed input sample.
bypass  input  1  1 = output the raw accepted sample instead of the average.
out_valid  output  1  out_data holds an unconsumed result.
out_ready  input  1  downstream accepts out_data this cycle (codec write_ready).
out_data  output  W  signed result.
busy  output  1  high while the history buffer is being cleared.

Behaviour:
- Reset: state = CLEAR, clear pointer = 0, write pointer = 0, sum = 0, out_valid = 0, out_data = 0, busy = 1, in_ready = 0.
- CLEAR state: writes 0 into one buffer entry per cycle at the clear pointer. After entry N-1 is written, the next state is RUN. CLEAR lasts exactly N cycles after reset deasserts. in_ready = 0 and busy = 1 throughout.
- RUN state: busy = 0. in_ready = !out_valid || out_ready, which permits back-to-back transfers.
- Accept occurs when in_valid && in_ready. In the accept cycle:
  - oldest = buf[wptr].
  - buf[wptr] <= in_data.
  - wptr <= wptr + 1, wrapping modulo N.
  - sum <= sum + sext(in_data) - sext(oldest).
  - out_data <= bypass ? in_data : (sum + sext(in_data) - sext(oldest)) >>> LOG_N (arithmetic shift, truncating toward -inf).
  - out_valid <= 1.
- Sum register is W+LOG_N bits signed, so it never overflows. The averaged output always fits in W bits, so no saturation is needed.
- Latency: a sample accepted at edge k is visible on out_data with out_valid = 1 after edge k.
- Output handshake: out_valid && out_ready with no accept in the same cycle sets out_valid <= 0. Accept and drain in the same cycle load the new result and keep out_valid = 1.
- Stall: while out_valid && !out_ready, out_data is held stable, in_ready = 0, and the buffer and sum are frozen.
- bypass affects only the out_data selection. The buffer and sum update on every accept, so toggling bypass causes no transient. bypass is sampled in the accept cycle only.
- in_valid while in CLEAR is ignored (no accept). The upstream codec holds its sample until read is asserted.
- reset asserted mid-operation takes priority over every other action: it discards the pending output and restarts CLEAR.
- Warm-up: the first N-1 outputs after CLEAR average against zeros. This is intended, not flagged.

Decomposition:
- Shared package: the RUN/CLEAR state encoding and a helper constant for the sum width (W+LOG_N).
- Sub-module circ_buf: an N×W single-write, single-read register array with a pointer-addressed read of the oldest entry, write-enable, and wrap logic.
- The top level holds the FSM, sum, and output register.

Test Plan:
- Reset release, in_valid held 1 -> busy = 1 and in_ready = 0 for exactly 8 cycles; first accept on cycle 9; out_data = 0 for in_data = 0.
- LOG_N = 3, out_ready = 1, 8 samples of +800 back-to-back -> outputs 100, 200, …, 800. A 9th sample of +800 gives out_data = 800 (steady state).
- Negative step: steady state at 800, then 8 samples of -800 -> the outputs fall by 200 per sample to -800. A single -1 after a zeroed buffer gives out_data = -1 (arithmetic shift floor). The buffer is pre-cleared because a prior reset leaves all entries at 0.
- Backpressure: out_ready = 0 for 5 cycles with in_valid = 1 -> in_ready = 0, out_data stable, sum unchanged. When out_ready returns to 1, the next sample is accepted in that same cycle.
- Bypass toggle: steady state at 400, then bypass = 1 with a sample of 1000 -> out_data = 1000. Next sample 400 with bypass = 0 -> out_data = (7·400 + 1000 + 400 - 400 replaced history) matches the reference model of the last 8 samples, i.e. 475.
- Mid-stream reset after 5 samples -> out_valid = 0 next cycle and CLEAR restarts. The next output equals the first sample divided by 8, with no trace of the old history.

Source files
------------

// File: rtl/moving_avg_stage_pkg.sv
// Shared types and sizing helpers for the moving-average stage.
package moving_avg_stage_pkg;

   typedef enum logic {
      StClear = 1'b0,
      StRun   = 1'b1
   } state_e;

   localparam int unsigned DefaultW    = 24;
   localparam int unsigned DefaultLogN = 3;

   // Running sum needs LOG_N guard bits so N full-scale samples never overflow.
   function automatic int unsigned sum_width(int unsigned w, int unsigned log_n);
      return w + log_n;
   endfunction

endpackage

// File: rtl/moving_avg_stage_if.sv
// Sample-in / result-out handshake bundle for one moving-average channel.
interface moving_avg_stage_if #(
   parameter int unsigned W = moving_avg_stage_pkg::DefaultW
) ();

   logic                in_valid;
   logic                in_ready;
   logic signed [W-1:0] in_data;
   logic                bypass;
   logic                out_valid;
   logic                out_ready;
   logic signed [W-1:0] out_data;
   logic                busy;

   modport master (
      output in_valid,
      output in_data,
      output bypass,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  busy
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  bypass,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output busy
   );

endinterface

// File: rtl/moving_avg_stage_circ_buf.sv
// N-entry circular sample history; reads the entry about to be overwritten (the oldest).
module moving_avg_stage_circ_buf #(
   parameter int unsigned W     = 24,
   parameter int unsigned LOG_N = 3
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         wr_en_i,
   input  logic [W-1:0] wr_data_i,
   output logic [W-1:0] oldest_o
);

   localparam int unsigned N = 1 << LOG_N;

   logic [W-1:0]     mem_q [N];
   logic [LOG_N-1:0] ptr_q, ptr_d;

   assign oldest_o = mem_q[ptr_q];

   // N is a power of two, so the pointer wraps naturally.
   always_comb begin
      ptr_d = ptr_q;
      if (wr_en_i) begin
         ptr_d = ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[ptr_q] <= wr_data_i;
      end
   end

endmodule

// File: rtl/moving_avg_stage.sv
// Per-channel 2^LOG_N-tap moving average with a valid/ready output register and raw bypass.
module moving_avg_stage
   import moving_avg_stage_pkg::*;
#(
   parameter int unsigned W     = DefaultW,
   parameter int unsigned LOG_N = DefaultLogN
) (
   input logic               CLOCK_50,
   input logic               reset,
   moving_avg_stage_if.slave bus
);

   localparam int unsigned SumW = sum_width(W, LOG_N);

   state_e                 state_q, state_d;
   logic [LOG_N-1:0]       clr_cnt_q, clr_cnt_d;
   logic signed [SumW-1:0] sum_q, sum_d, sum_nxt, avg;
   logic signed [SumW-1:0] in_ext, old_ext;
   logic                   out_valid_q, out_valid_d;
   logic [W-1:0]           out_data_q, out_data_d;
   logic                   run, in_rdy, accept;
   logic                   buf_we;
   logic [W-1:0]           buf_wdata, oldest;

   assign run    = (state_q == StRun);
   assign in_rdy = run && (!out_valid_q || bus.out_ready);
   assign accept = bus.in_valid && in_rdy;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q   <= StClear;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      unique case (state_q)
         StClear: begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (&clr_cnt_q) begin
               state_d = StRun;
            end
         end
         StRun: begin
            state_d = StRun;
         end
      endcase
   end

   // CLEAR zeroes one history entry per cycle; RUN writes only on accept.
   always_comb begin
      bus.busy     = 1'b1;
      bus.in_ready = 1'b0;
      buf_we       = 1'b0;
      buf_wdata    = '0;
      unique case (state_q)
         StClear: begin
            buf_we = 1'b1;
         end
         StRun: begin
            bus.busy     = 1'b0;
            bus.in_ready = in_rdy;
            buf_we       = accept;
            buf_wdata    = bus.in_data;
         end
      endcase
   end

   moving_avg_stage_circ_buf #(
      .W     (W),
      .LOG_N (LOG_N)
   ) u_circ_buf (
      .clk_i     (CLOCK_50),
      .rst_i     (reset),
      .wr_en_i   (buf_we),
      .wr_data_i (buf_wdata),
      .oldest_o  (oldest)
   );

   assign in_ext  = {{LOG_N{bus.in_data[W-1]}}, bus.in_data};
   assign old_ext = {{LOG_N{oldest[W-1]}}, oldest};
   assign sum_nxt = sum_q + in_ext - old_ext;
   assign avg     = sum_nxt >>> LOG_N;

   always_comb begin
      sum_d       = sum_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (accept) begin
         sum_d       = sum_nxt;
         out_data_d  = bus.bypass ? bus.in_data : avg[W-1:0];
         out_valid_d = 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         sum_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         sum_q       <= sum_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_moving_avg_stage.sv
// Directed plus randomized bench for moving_avg_stage against a queue-based average model.
module tb_moving_avg_stage;

   localparam int W     = 24;
   localparam int LOG_N = 3;
   localparam int N     = 1 << LOG_N;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   moving_avg_stage_if #(.W(W)) bus ();

   moving_avg_stage #(
      .W     (W),
      .LOG_N (LOG_N)
   ) dut (
      .CLOCK_50 (clk),
      .reset    (reset),
      .bus      (bus)
   );

   int checks = 0;
   int errors = 0;

   int hist[$];
   int clear_left;
   bit m_ov;
   int m_od;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0d exp %0d", tag, $signed(got), $signed(exp));
      end
   endtask

   function automatic int floor_div(input int s);
      int q;
      q = s / N;
      if ((s % N != 0) && (s < 0)) q = q - 1;
      return q;
   endfunction

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < N; i++) hist.push_back(0);
      clear_left = N;
      m_ov       = 1'b0;
      m_od       = 0;
   endtask

   // One clock: drive, check combinational handshake, advance model, check registered outputs.
   task automatic step(input bit rst, input bit v, input int d, input bit byp, input bit ordy);
      bit exp_rdy;
      int s;
      reset         = rst;
      bus.in_valid  = v;
      bus.in_data   = d[W-1:0];
      bus.bypass    = byp;
      bus.out_ready = ordy;
      #2;
      exp_rdy = (clear_left == 0) && (!m_ov || ordy);
      chk("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_rdy});
      chk("busy", {31'b0, bus.busy}, {31'b0, clear_left > 0});
      if (rst) begin
         model_reset();
      end else if (clear_left > 0) begin
         clear_left--;
      end else if (v && exp_rdy) begin
         hist.push_back(d);
         void'(hist.pop_front());
         s = 0;
         foreach (hist[i]) s += hist[i];
         m_od = byp ? d : floor_div(s);
         m_ov = 1'b1;
      end else if (m_ov && ordy) begin
         m_ov = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("out_valid", {31'b0, bus.out_valid}, {31'b0, m_ov});
      chk("out_data", bus.out_data, m_od);
   endtask

   task automatic clear_cycles(input bit v, input int d);
      for (int i = 0; i < N; i++) step(1'b0, v, d, 1'b0, 1'b1);
   endtask

   initial begin
      int d;
      bus.in_valid  = 1'b1;
      bus.in_data   = '0;
      bus.bypass    = 1'b0;
      bus.out_ready = 1'b1;
      reset         = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_out_data", bus.out_data, 32'd0);
      chk("rst_busy", {31'b0, bus.busy}, 32'd1);
      chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
      step(1'b1, 1'b1, 0, 1'b0, 1'b1);

      // Clear window with in_valid held high, then first accept of 0.
      clear_cycles(1'b1, 0);
      step(1'b0, 1'b1, 0, 1'b0, 1'b1);
      chk("first_accept_zero", bus.out_data, 32'd0);

      // Positive ramp to steady state, then negative step.
      for (int i = 0; i < N + 1; i++) step(1'b0, 1'b1, 800, 1'b0, 1'b1);
      chk("steady_800", bus.out_data, 32'd800);
      for (int i = 0; i < N; i++) step(1'b0, 1'b1, -800, 1'b0, 1'b1);
      chk("steady_m800", bus.out_data, -32'sd800);

      // Floor behaviour of the arithmetic shift on a freshly cleared history.
      step(1'b1, 1'b0, 0, 1'b0, 1'b1);
      clear_cycles(1'b0, 0);
      step(1'b0, 1'b1, -1, 1'b0, 1'b1);
      chk("floor_m1", bus.out_data, -32'sd1);

      // Backpressure: five stalled cycles, then accept on the cycle out_ready returns.
      for (int i = 0; i < N; i++) step(1'b0, 1'b1, 400, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1234, 1'b0, 1'b0);
      chk("stall_hold", bus.out_data, 32'd400);
      step(1'b0, 1'b1, 1234, 1'b0, 1'b1);

      // Bypass toggle.
      for (int i = 0; i < N; i++) step(1'b0, 1'b1, 400, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1000, 1'b1, 1'b1);
      chk("bypass_raw", bus.out_data, 32'd1000);
      step(1'b0, 1'b1, 400, 1'b0, 1'b1);
      chk("bypass_after", bus.out_data, 32'd475);

      // Mid-stream reset discards history and pending output.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 7000 * (i + 1), 1'b0, 1'b1);
      step(1'b1, 1'b1, 0, 1'b0, 1'b0);
      chk("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      clear_cycles(1'b1, 4000);
      step(1'b0, 1'b1, 4000, 1'b0, 1'b1);
      chk("midrst_first", bus.out_data, 32'd500);

      // Randomized traffic with occasional reset.
      for (int i = 0; i < 400; i++) begin
         d = int'($urandom % 32'd16777216) - 8388608;
         step($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0, d,
              $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
